// File: rtl/cdma_wr_eng_if.sv
// cdma_wr_eng_if: control, buffer read side and AHB-Lite
// master signals of the CDMA write engine.
interface cdma_wr_eng_if;
   logic        start;
   logic [31:0] dst_addr;
   logic [15:0] len_word;
   logic        busy;
   logic        done;
   logic        err;
   logic        buf_rd;
   logic [31:0] buf_rdata;
   logic [5:0]  buf_buf_word;
   logic        buf_empty;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;

   modport master (
      input  start, dst_addr, len_word,
      input  buf_rdata, buf_buf_word, buf_empty,
      input  hready, hresp,
      output busy, done, err, buf_rd,
      output htrans, haddr, hburst, hsize, hwrite, hwdata
   );

   modport slave (
      output start, dst_addr, len_word,
      output buf_rdata, buf_buf_word, buf_empty,
      output hready, hresp,
      input  busy, done, err, buf_rd,
      input  htrans, haddr, hburst, hsize, hwrite, hwdata
   );
endinterface

// File: rtl/cdma_wr_eng.sv
// cdma_wr_eng: drains buffered words onto AHB-Lite as
// INCR4 bursts when possible, SINGLE transfers otherwise.
module cdma_wr_eng (
   input logic           clk,
   input logic           rstn,
   cdma_wr_eng_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [1:0] TR_IDLE = 2'b00;
   localparam logic [1:0] TR_NSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ  = 2'b11;
   localparam logic [2:0] HB_SNGL = 3'b000;
   localparam logic [2:0] HB_INC4 = 3'b011;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [15:0] rem_a_q;
   logic [15:0] rem_d_q;
   logic [2:0]  resv_q;
   logic [1:0]  beat_q;
   logic        dphase_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [1:0]  htrans_q;
   logic [2:0]  hburst_q;

   logic        xfer;
   logic        accept;
   logic        acc;
   logic        pop;
   logic        dpop;
   logic        err_hit;
   logic [31:0] addr_d;
   logic [15:0] rem_a_d;
   logic [15:0] rem_d_d;
   logic [2:0]  resv_d;
   logic [1:0]  beat_d;
   logic        dphase_d;
   logic        use4;
   logic [6:0]  need;
   logic        can_iss;
   logic [1:0]  htrans_d;
   logic [2:0]  hburst_d;

   // Bus events of this cycle and the bookkeeping they imply.
   always_comb begin
      xfer    = (state_q == S_XFER);
      accept  = bus.start && (state_q == S_IDLE);
      acc     = xfer && (htrans_q != TR_IDLE) && bus.hready;
      pop     = xfer && dphase_q && bus.hready
                && !bus.hresp && !bus.buf_empty;
      err_hit = xfer && dphase_q && bus.hresp;
      dpop    = (state_q == S_DRAIN) && (rem_d_q != 16'd0)
                && !bus.buf_empty;
      if (accept) begin
         addr_d   = bus.dst_addr & ~32'h3;
         rem_a_d  = bus.len_word;
         rem_d_d  = bus.len_word;
         resv_d   = 3'd0;
         beat_d   = 2'd0;
         dphase_d = 1'b0;
      end else begin
         addr_d   = acc ? addr_q + 32'd4 : addr_q;
         rem_a_d  = rem_a_q - {15'd0, acc};
         rem_d_d  = rem_d_q - {15'd0, pop | dpop};
         resv_d   = resv_q + {2'd0, acc} - {2'd0, pop};
         beat_d   = beat_q;
         if (acc)
            beat_d = (hburst_q == HB_INC4) ? beat_q + 2'd1 : 2'd0;
         dphase_d = acc | (dphase_q & ~pop);
      end
      use4 = (rem_a_d >= 16'd4) && (addr_d[9:0] <= 10'h3F0);
      // Words in the buffer not yet claimed by an issued beat;
      // the word popped this cycle still counts as claimed.
      need = (use4 ? 7'd4 : 7'd1);
      if (!accept)
         need = need + {4'd0, resv_q} + {6'd0, acc};
      can_iss = {1'b0, bus.buf_buf_word} >= need;
   end

   // Next address-phase control; a burst never pauses once started.
   always_comb begin
      htrans_d = TR_IDLE;
      hburst_d = hburst_q;
      if (err_hit) begin
         htrans_d = TR_IDLE;
      end else if (accept || (xfer && bus.hready)) begin
         if (beat_d != 2'd0) begin
            htrans_d = TR_SEQ;
         end else if (rem_a_d != 16'd0 && can_iss) begin
            htrans_d = TR_NSEQ;
            hburst_d = use4 ? HB_INC4 : HB_SNGL;
         end
      end else if (xfer) begin
         htrans_d = htrans_q;
      end
   end

   // Transfer FSM and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'd0;
         rem_a_q  <= 16'd0;
         rem_d_q  <= 16'd0;
         resv_q   <= 3'd0;
         beat_q   <= 2'd0;
         dphase_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         htrans_q <= TR_IDLE;
         hburst_q <= HB_SNGL;
      end else begin
         addr_q   <= addr_d;
         rem_a_q  <= rem_a_d;
         rem_d_q  <= rem_d_d;
         resv_q   <= resv_d;
         beat_q   <= beat_d;
         dphase_q <= dphase_d;
         htrans_q <= htrans_d;
         hburst_q <= hburst_d;
         done_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  state_q <= S_XFER;
               end
            end
            S_XFER: begin
               if (err_hit) begin
                  err_q    <= 1'b1;
                  dphase_q <= 1'b0;
                  state_q  <= S_DRAIN;
               end else if (rem_d_d == 16'd0) begin
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
               end
            end
            S_DRAIN: begin
               if (rem_d_d == 16'd0) begin
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
               end
            end
            S_FIN: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.buf_rd = pop | dpop;
   assign bus.htrans = htrans_q;
   assign bus.haddr  = addr_q;
   assign bus.hburst = hburst_q;
   assign bus.hsize  = 3'b010;
   assign bus.hwrite = busy_q;
   assign bus.hwdata = bus.buf_rdata;
endmodule

// File: tb/tb_cdma_wr_eng.sv
// tb_cdma_wr_eng: directed bench for the CDMA write engine
// with a buffer model and an AHB-Lite slave model.
module tb_cdma_wr_eng;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   cdma_wr_eng_if bus ();
   cdma_wr_eng dut (.clk(clk), .rstn(rstn), .bus(bus));

   localparam logic [4:0] NS4 = 5'b10011;
   localparam logic [4:0] SQ4 = 5'b11011;
   localparam logic [4:0] NS1 = 5'b10000;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int st_cyc = 0;
   int done_at = -1;
   logic [31:0] q[$];
   int src_seq = 0;
   int pop_seq = 0;
   int fill_per = 0;
   int fill_left = 0;
   int hr_rand = 0;
   int err_beat = 0;
   int err_stage = 0;
   int dp_idx = 0;
   int n_acc, n_pop, last_pop, first_acc, post_err;
   int v_empty, v_wait, v_unst, v_starve;
   logic [31:0] a_addr[$];
   logic [4:0]  a_ctl[$];
   logic [31:0] e_addr[$];
   logic [4:0]  e_ctl[$];
   logic [1:0]  p_tr;
   logic [31:0] p_ad;
   logic [2:0]  p_hb;
   logic        p_hr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic upd_buf();
      bus.buf_buf_word = 6'(q.size());
      bus.buf_empty = (q.size() == 0);
      bus.buf_rdata = (q.size() > 0) ? q[0] : 32'h0;
   endtask

   task automatic push_word();
      q.push_back(32'hD000_0000 + 32'(src_seq));
      src_seq++;
   endtask

   task automatic prefill(input int n);
      for (int i = 0; i < n; i++) push_word();
      upd_buf();
   endtask

   task automatic ex(input logic [31:0] a, input logic [4:0] c);
      e_addr.push_back(a);
      e_ctl.push_back(c);
   endtask

   // sample just before the edge, then advance one cycle
   task automatic tick();
      logic rd, emp, hr, acc;
      logic [31:0] hw;
      rd  = bus.buf_rd;
      emp = bus.buf_empty;
      hr  = bus.hready;
      hw  = bus.hwdata;
      acc = (bus.htrans != 2'b00) && hr;
      if (rd && emp) v_empty++;
      if (rd && !hr && err_beat == 0) v_wait++;
      if (fill_per > 0) begin
         if (bus.htrans == 2'b10 && bus.hburst == 3'b011
             && bus.buf_buf_word < 6'd4) v_starve++;
         if (n_acc == 0 && bus.buf_buf_word < 6'd4
             && bus.htrans != 2'b00) v_starve++;
      end
      if (acc) begin
         a_addr.push_back(bus.haddr);
         a_ctl.push_back({bus.htrans, bus.hburst});
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
         if (err_stage != 0) post_err++;
      end
      if (rd) chk("pop_data", hw, 32'hD000_0000 + 32'(pop_seq));
      p_tr = bus.htrans;
      p_ad = bus.haddr;
      p_hb = bus.hburst;
      p_hr = hr;
      @(posedge clk);
      #1;
      if (rd && q.size() > 0) begin
         void'(q.pop_front());
         n_pop++;
         pop_seq++;
         last_pop = cyc;
      end
      cyc++;
      if (acc) dp_idx = n_acc;
      else if (hr) dp_idx = 0;
      if (fill_per > 0 && fill_left > 0 && cyc % fill_per == 0) begin
         push_word();
         fill_left--;
      end
      upd_buf();
   endtask

   task automatic run(input logic [31:0] dst, input logic [15:0] len,
                      input int budget);
      bit seen;
      a_addr.delete();
      a_ctl.delete();
      n_acc = 0; n_pop = 0; last_pop = -1; first_acc = -1;
      post_err = 0; v_empty = 0; v_wait = 0; v_unst = 0;
      v_starve = 0; dp_idx = 0; err_stage = 0; done_at = -1;
      bus.start = 1'b1;
      bus.dst_addr = dst;
      bus.len_word = len;
      bus.hready = 1'b1;
      bus.hresp = 1'b0;
      st_cyc = cyc;
      #1;
      tick();
      bus.start = 1'b0;
      seen = 1'b0;
      for (int c = 1; c < budget && !seen; c++) begin
         if (err_beat > 0 && err_stage == 0 && dp_idx == err_beat)
            err_stage = 1;
         if (err_stage == 1) begin
            bus.hready = 1'b0;
            bus.hresp = 1'b1;
         end else if (err_stage == 2) begin
            bus.hready = 1'b1;
            bus.hresp = 1'b1;
         end else begin
            bus.hresp = 1'b0;
            bus.hready = (hr_rand != 0 && $urandom_range(0, 3) == 0)
                         ? 1'b0 : 1'b1;
         end
         #1;
         if (c == 1) begin
            chk("busy_t1", bus.busy, 1);
            chk("err_clr", bus.err, 0);
         end
         if (err_stage == 2) begin
            chk("err_idle", bus.htrans, 0);
            chk("err_flag", bus.err, 1);
         end
         if (!p_hr && p_tr != 2'b00 && err_stage == 0
             && (bus.htrans != p_tr || bus.haddr != p_ad
                 || bus.hburst != p_hb)) v_unst++;
         if (bus.done) begin
            seen = 1'b1;
            done_at = cyc;
         end
         tick();
         if (err_stage == 1) err_stage = 2;
         else if (err_stage == 2) err_stage = 3;
      end
      bus.hready = 1'b1;
      bus.hresp = 1'b0;
      chk("done_seen", seen, 1);
      chk("busy_after", bus.busy, 0);
      chk("pop_cnt", n_pop, len);
      chk("no_pop_empty", v_empty, 0);
   endtask

   task automatic cmp_list();
      chk("acc_cnt", a_addr.size(), e_addr.size());
      foreach (e_addr[i]) begin
         if (i < a_addr.size()) begin
            chk("acc_addr", a_addr[i], e_addr[i]);
            chk("acc_ctl", a_ctl[i], e_ctl[i]);
         end
      end
      e_addr.delete();
      e_ctl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.dst_addr = 32'h0;
      bus.len_word = 16'h0;
      bus.hready = 1'b1;
      bus.hresp = 1'b0;
      upd_buf();
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_buf_rd", bus.buf_rd, 0);
      chk("rst_htrans", bus.htrans, 0);
      chk("rst_haddr", bus.haddr, 0);
      chk("rst_hburst", bus.hburst, 0);
      chk("rst_hwrite", bus.hwrite, 0);
      chk("rst_hsize", bus.hsize, 3'b010);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // two aligned INCR4 bursts
      prefill(8);
      for (int i = 0; i < 8; i++)
         ex(32'h1000 + 32'(4 * i), (i % 4 == 0) ? NS4 : SQ4);
      run(32'h1000, 16'd8, 100);
      cmp_list();
      chk("t1_first_nseq", first_acc - st_cyc, 1);
      chk("t1_done_lat", done_at - last_pop, 1);
      chk("t1_err", bus.err, 0);

      // 1 KB boundary, low address bits ignored, short tail
      prefill(8);
      ex(32'h13F8, NS1);
      ex(32'h13FC, NS1);
      ex(32'h1400, NS4);
      ex(32'h1404, SQ4);
      ex(32'h1408, SQ4);
      ex(32'h140C, SQ4);
      ex(32'h1410, NS1);
      ex(32'h1414, NS1);
      run(32'h13FB, 16'd8, 100);
      cmp_list();
      chk("t2_done_lat", done_at - last_pop, 1);

      // starved buffer, one word every 3 cycles
      fill_per = 3;
      fill_left = 5;
      for (int i = 0; i < 4; i++)
         ex(32'h3000 + 32'(4 * i), (i == 0) ? NS4 : SQ4);
      ex(32'h3010, NS1);
      run(32'h3000, 16'd5, 100);
      fill_per = 0;
      cmp_list();
      chk("t3_starve", v_starve, 0);

      // random wait states
      hr_rand = 1;
      prefill(20);
      for (int i = 0; i < 20; i++)
         ex(32'h2000 + 32'(4 * i), (i % 4 == 0) ? NS4 : SQ4);
      run(32'h2000, 16'd20, 300);
      hr_rand = 0;
      cmp_list();
      chk("t4_no_pop_wait", v_wait, 0);
      chk("t4_stable", v_unst, 0);
      chk("t4_done_lat", done_at - last_pop, 1);

      // ERROR response on the third beat
      err_beat = 3;
      prefill(12);
      ex(32'h4000, NS4);
      ex(32'h4004, SQ4);
      ex(32'h4008, SQ4);
      run(32'h4000, 16'd12, 100);
      err_beat = 0;
      cmp_list();
      chk("t5_no_bus_after_err", post_err, 0);
      chk("t5_err_sticky", bus.err, 1);
      chk("t5_done_lat", done_at - last_pop, 1);

      // zero length
      run(32'h0000_6000, 16'd0, 20);
      cmp_list();
      chk("t6_done_lat", done_at - st_cyc, 2);

      // asynchronous reset in the middle of a burst
      prefill(8);
      bus.start = 1'b1;
      bus.dst_addr = 32'h5000;
      bus.len_word = 16'd8;
      #1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("t7_mid_busy", bus.busy, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t7_busy", bus.busy, 0);
      chk("t7_done", bus.done, 0);
      chk("t7_err", bus.err, 0);
      chk("t7_buf_rd", bus.buf_rd, 0);
      chk("t7_htrans", bus.htrans, 0);
      chk("t7_haddr", bus.haddr, 0);
      chk("t7_hburst", bus.hburst, 0);
      chk("t7_hwrite", bus.hwrite, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      q.delete();
      upd_buf();
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
